bram_arbiter: RTL and testbench

//  Shares one byte-wide bram_port between two word-level requesters (e.g. flip engine and host loader).

---
 rtl/bram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one byte-wide BRAM port between two word-level
// requesters. A granted word request is sequenced as WORD_BYTES byte
// accesses, assembled little-endian (byte i at base+i, addresses wrap mod 256).
// Optional build macro ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous
// requests. Without it the arbiter alternates between requesters (round-robin).
module bram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_BYTES = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [1:0]                       req,
   input  logic [1:0]                       we,
   input  logic [7:0]                       addr0,
   input  logic [7:0]                       addr1,
   input  logic [WORD_BYTES*DATA_WIDTH-1:0] wdata0,
   input  logic [WORD_BYTES*DATA_WIDTH-1:0] wdata1,
   output logic [1:0]                       gnt,
   output logic [1:0]                       done,
   output logic [WORD_BYTES*DATA_WIDTH-1:0] rdata,
   output logic                             busy,
   output logic                             bram_ena,
   output logic                             bram_we,
   output logic [7:0]                       bram_addr,
   output logic [DATA_WIDTH-1:0]            bram_din,
   input  logic [DATA_WIDTH-1:0]            bram_dout
);

   localparam int WW = WORD_BYTES * DATA_WIDTH;
   localparam int CW = 2;

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            id_q;
   logic [7:0]      base_q;
   logic [WW-1:0]   wdata_q;
   logic [WW-1:0]   rbuf_q;
   logic [WW-1:0]   rdata_q;
   logic [1:0]      gnt_q;
   logic [1:0]      done_q;
   logic            busy_q;
   logic            ena_q;
   logic            bwe_q;
   logic [7:0]      baddr_q;
   logic [DATA_WIDTH-1:0] din_q;
`ifndef ARB_FIXED_PRIO_EN
   logic            rr_q;
`endif

   logic            gid_d;
   logic [7:0]      gaddr_d;
   logic [WW-1:0]   gwdata_d;
   logic [CW-1:0]   nxt_cnt_d;
   logic            last_d;
   logic [WW-1:0]   rbuf_d;
   logic [DATA_WIDTH-1:0] wbyte_d;

   // Pick the requester to serve if a grant happens this cycle
   always_comb begin
      gid_d = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      gid_d = ~req[0];
`else
      if (req == 2'b11) gid_d = rr_q;
      else              gid_d = req[1];
`endif
      gaddr_d  = gid_d ? addr1 : addr0;
      gwdata_d = gid_d ? wdata1 : wdata0;
   end

   // Byte-lane helpers: next counter, read-byte merge and next write byte
   always_comb begin
      nxt_cnt_d = cnt_q + 1'b1;
      last_d    = (cnt_q == CW'(WORD_BYTES - 1));
      rbuf_d    = rbuf_q;
      wbyte_d   = '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (cnt_q == CW'(i))     rbuf_d[i*DATA_WIDTH +: DATA_WIDTH] = bram_dout;
         if (nxt_cnt_d == CW'(i)) wbyte_d = wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Transfer sequencer; every output is a register set on state entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         id_q    <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         ena_q   <= 1'b0;
         bwe_q   <= 1'b0;
         baddr_q <= '0;
         din_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
         rr_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  id_q    <= gid_d;
                  base_q  <= gaddr_d;
                  wdata_q <= gwdata_d;
                  cnt_q   <= '0;
                  gnt_q   <= gid_d ? 2'b10 : 2'b01;
                  busy_q  <= 1'b1;
                  ena_q   <= 1'b1;
                  baddr_q <= gaddr_d;
                  if (we[gid_d]) begin
                     bwe_q   <= 1'b1;
                     din_q   <= gwdata_d[DATA_WIDTH-1:0];
                     state_q <= WR;
                  end else begin
                     state_q <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               ena_q   <= 1'b0;
               state_q <= RD_DATA;
            end
            RD_DATA: begin
               rbuf_q <= rbuf_d;
               if (last_d) begin
                  rdata_q <= rbuf_d;
                  done_q  <= id_q ? 2'b10 : 2'b01;
                  state_q <= DONE;
               end else begin
                  cnt_q   <= nxt_cnt_d;
                  ena_q   <= 1'b1;
                  baddr_q <= base_q + 8'(nxt_cnt_d);
                  state_q <= RD_ADDR;
               end
            end
            WR: begin
               if (last_d) begin
                  ena_q   <= 1'b0;
                  bwe_q   <= 1'b0;
                  done_q  <= id_q ? 2'b10 : 2'b01;
                  state_q <= DONE;
               end else begin
                  cnt_q   <= nxt_cnt_d;
                  baddr_q <= base_q + 8'(nxt_cnt_d);
                  din_q   <= wbyte_d;
               end
            end
            DONE: begin
               done_q  <= '0;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
               rr_q    <= ~id_q;
`endif
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign bram_ena  = ena_q;
   assign bram_we   = bwe_q;
   assign bram_addr = baddr_q;
   assign bram_din  = din_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: behavioural BRAM, table of word transfers,
// scoreboard of expected completions, plus reset-abort and arbitration sequences.
module tb_bram_arbiter;

   localparam int DW = 8;
   localparam int WB = 2;

   logic            clk;
   logic            reset_n;
   logic [1:0]      req;
   logic [1:0]      we;
   logic [7:0]      addr0;
   logic [7:0]      addr1;
   logic [15:0]     wdata0;
   logic [15:0]     wdata1;
   logic [1:0]      gnt;
   logic [1:0]      done;
   logic [15:0]     rdata;
   logic            busy;
   logic            bram_ena;
   logic            bram_we;
   logic [7:0]      bram_addr;
   logic [7:0]      bram_din;
   logic [7:0]      bram_dout;

   logic [7:0]      mem [0:255];

   typedef struct {
      logic        id;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic        id;
      logic        wr;
      logic [15:0] rd;
      int          lat;
   } sb_t;

   vec_t        vecs [7];
   sb_t         sbq [$];
   logic [15:0] wlog [$];
   logic        glog [$];
   int          n_chk;
   int          n_fail;

   bram_arbiter #(.DATA_WIDTH(DW), .WORD_BYTES(WB)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .bram_ena(bram_ena), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_din(bram_din), .bram_dout(bram_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first BRAM, one cycle read latency
   always @(posedge clk) begin
      if (bram_ena) begin
         if (bram_we) mem[bram_addr] <= bram_din;
         bram_dout <= mem[bram_addr];
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hAB;
      mem[8'h11] <= 8'hCD;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: invariants, grant log, write log, scoreboard pops on done
   initial begin
      int   gcnt;
      logic [1:0] gprev;
      sb_t  e;
      gcnt  = 0;
      gprev = 2'b00;
      forever begin
         @(negedge clk);
         if (gnt != 2'b00) gcnt++;
         else              gcnt = 0;
         if (gnt != 2'b00 && gprev == 2'b00) glog.push_back(gnt[1]);
         gprev = gnt;
         if (bram_we) wlog.push_back({bram_addr, bram_din});
         chk("gnt_onehot", 32'(gnt == 2'b11), 32'd0);
         chk("done_onehot", 32'(done == 2'b11), 32'd0);
         chk("we_needs_ena", 32'(bram_we && !bram_ena), 32'd0);
         if (done != 2'b00) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done: done=%b with no transfer outstanding at %0t", done, $time);
            end else begin
               e = sbq.pop_front();
               chk("done_id", 32'(done), 32'(e.id ? 2'b10 : 2'b01));
               chk("done_with_gnt", 32'(gnt), 32'(done));
               chk("latency", 32'(gcnt), 32'(e.lat));
               if (!e.wr) chk("rdata", 32'(rdata), 32'(e.rd));
            end
         end
      end
   end

   task automatic wait_done(input logic id, output bit got);
      got = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (done[id]) begin
            got = 1'b1;
            break;
         end
      end
      chk("done_timeout", 32'(got), 32'd1);
   endtask

   task automatic do_xfer(input vec_t v);
      bit   got;
      sb_t  e;
      logic [7:0] a;
      @(negedge clk);
      wlog.delete();
      if (v.id) begin
         we[1] = v.wr; addr1 = v.addr; wdata1 = v.wdata;
      end else begin
         we[0] = v.wr; addr0 = v.addr; wdata0 = v.wdata;
      end
      req[v.id] = 1'b1;
      e.id  = v.id;
      e.wr  = v.wr;
      e.rd  = v.exp;
      e.lat = v.wr ? WB + 1 : 2 * WB + 1;
      sbq.push_back(e);
      wait_done(v.id, got);
      req[v.id] = 1'b0;
      if (v.wr) begin
         chk("wr_beats", 32'(wlog.size()), 32'(WB));
         for (int i = 0; i < WB; i++) begin
            a = v.addr + 8'(i);
            if (i < wlog.size()) chk("wr_beat", 32'(wlog[i]), 32'({a, v.wdata[i*8 +: 8]}));
            chk("mem_byte", 32'(mem[a]), 32'(v.wdata[i*8 +: 8]));
         end
      end else begin
         chk("rd_no_we", 32'(wlog.size()), 32'd0);
      end
   endtask

   initial begin
      bit   got;
      int   ndone;
      sb_t  e;
      vec_t v;
      logic exp_id [4];

      n_chk = 0;
      n_fail = 0;
      vecs[0] = '{id: 1'b0, wr: 1'b0, addr: 8'h10, wdata: 16'h0000, exp: 16'hCDAB};
      vecs[1] = '{id: 1'b1, wr: 1'b1, addr: 8'h20, wdata: 16'h1234, exp: 16'h0000};
      vecs[2] = '{id: 1'b0, wr: 1'b0, addr: 8'h20, wdata: 16'h0000, exp: 16'h1234};
      vecs[3] = '{id: 1'b0, wr: 1'b1, addr: 8'hFF, wdata: 16'hBEEF, exp: 16'h0000};
      vecs[4] = '{id: 1'b1, wr: 1'b0, addr: 8'hFF, wdata: 16'h0000, exp: 16'hBEEF};
      vecs[5] = '{id: 1'b1, wr: 1'b1, addr: 8'h7E, wdata: 16'hA55A, exp: 16'h0000};
      vecs[6] = '{id: 1'b0, wr: 1'b0, addr: 8'h7E, wdata: 16'h0000, exp: 16'hA55A};

      reset_n = 1'b0;
      req = 2'b00; we = 2'b00;
      addr0 = 8'h00; addr1 = 8'h00;
      wdata0 = 16'h0000; wdata1 = 16'h0000;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({gnt, done, rdata, busy, bram_ena, bram_we, bram_addr, bram_din}), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_outputs", 32'({gnt, done, busy, bram_ena, bram_we}), 32'd0);

      for (int i = 0; i < 7; i++) do_xfer(vecs[i]);
      chk("wrap_mem_ff", 32'(mem[8'hFF]), 32'h00EF);
      chk("wrap_mem_00", 32'(mem[8'h00]), 32'h00BE);

      // Request dropped and inputs changed after grant: transfer still completes as latched
      @(negedge clk);
      wlog.delete();
      we[1] = 1'b0; addr1 = 8'h10; req[1] = 1'b1;
      e = '{id: 1'b1, wr: 1'b0, rd: 16'hCDAB, lat: 2 * WB + 1};
      sbq.push_back(e);
      got = 1'b0;
      for (int c = 0; c < 16 && !got; c++) begin
         @(negedge clk);
         if (gnt[1]) got = 1'b1;
      end
      chk("grant_timeout", 32'(got), 32'd1);
      req[1] = 1'b0; addr1 = 8'h20; we[1] = 1'b1;
      wait_done(1'b1, got);
      chk("drop_rd_no_we", 32'(wlog.size()), 32'd0);
      we[1] = 1'b0;

      // Reset during the second byte of a write aborts it
      @(negedge clk);
      we[0] = 1'b1; addr0 = 8'h40; wdata0 = 16'h7788; req[0] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 16 && !got; c++) begin
         @(negedge clk);
         if (bram_we && bram_addr == 8'h41) got = 1'b1;
      end
      chk("second_beat_seen", 32'(got), 32'd1);
      #1 reset_n = 1'b0;
      #1 chk("abort_outputs", 32'({gnt, done, rdata, busy, bram_ena, bram_we, bram_addr, bram_din}), 32'd0);
      req[0] = 1'b0; we[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_mem_40", 32'(mem[8'h40]), 32'h0088);
      chk("abort_mem_41", 32'(mem[8'h41]), 32'h0000);
      reset_n = 1'b1;
      v = '{id: 1'b0, wr: 1'b0, addr: 8'h10, wdata: 16'h0000, exp: 16'hCDAB};
      do_xfer(v);

      // Both requesters held high: grant order depends on the arbitration build
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0; exp_id[3] = 1'b0;
`else
      exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`endif
      for (int i = 0; i < 4; i++) begin
         e.id  = exp_id[i];
         e.wr  = 1'b0;
         e.rd  = exp_id[i] ? 16'h1234 : 16'hCDAB;
         e.lat = 2 * WB + 1;
         sbq.push_back(e);
      end
      glog.delete();
      we = 2'b00; addr0 = 8'h10; addr1 = 8'h20;
      req = 2'b11;
      ndone = 0;
      for (int c = 0; c < 200 && ndone < 4; c++) begin
         @(negedge clk);
         if (done != 2'b00) ndone++;
      end
      req = 2'b00;
      chk("contend_dones", 32'(ndone), 32'd4);
      chk("contend_grants", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < glog.size()) chk("grant_order", 32'(glog[i]), 32'(exp_id[i]));
      end

      repeat (4) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      chk("final_idle", 32'({gnt, busy, bram_ena, bram_we}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
